// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xlen_t;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard for RAW hazard detection, plus a registered
// any_busy summary flag. Register 0 is never busy.
module regfile_mp_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic              flush,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  output logic [NREGS-1:0]  busy,
  output logic              any_busy
);

  logic [NREGS-1:0] busy_nxt;

  // Priority, lowest to highest: writeback clear, issue set, flush.
  // An issue beats a same-cycle writeback because a newer producer is in flight.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NWR; j++) begin
      if (we[j]) busy_nxt[wa[j*AW +: AW]] = 1'b0;
    end
    if (iss_valid) busy_nxt[iss_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      any_busy <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      any_busy <= |busy;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Optional write-through forwarding when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic                any_busy
);

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy;

  regfile_mp_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .we        (we),
    .wa        (wa),
    .busy      (busy),
    .any_busy  (any_busy)
  );

  // Higher-index ports are assigned later, so they win address conflicts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREGS; k++) rf[k] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (wa[j*AW +: AW] != '0)) rf[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  logic [AW-1:0] raddr;
`ifdef REGFILE_MP_BYPASS_EN
  logic          byp;
`endif

  always_comb begin
    rd    = '0;
    rbusy = '0;
    raddr = '0;
`ifdef REGFILE_MP_BYPASS_EN
    byp   = 1'b0;
`endif
    for (int i = 0; i < NRD; i++) begin
      raddr = ra[i*AW +: AW];
      rd[i*XLEN +: XLEN] = (raddr == '0) ? '0 : rf[raddr];
      rbusy[i] = busy[raddr];
`ifdef REGFILE_MP_BYPASS_EN
      // Forward the highest-index matching write; a same-cycle issue keeps it busy.
      byp = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (we[j] && (raddr != '0) && (wa[j*AW +: AW] == raddr)) begin
          rd[i*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
          byp = 1'b1;
        end
      end
      if (byp && !(iss_valid && (iss_rd == raddr))) rbusy[i] = 1'b0;
`endif
    end
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, for the dual-issue pipeline. It provides NRD combinational read ports and NWR synchronous write ports. It keeps one busy bit per register, set when an instruction that writes that register issues and cleared on writeback, so decode can detect RAW hazards. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (≥1)
- NWR, 2, number of write/writeback ports (≥1)
- AW, $clog2(NREGS), address width (derived, not overridable)

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- we  in  NWR  per-port write enable; also clears the target's busy bit
- wa  in  NWR×AW  per-port write address
- wd  in  NWR×XLEN  per-port write data
- ra  in  NRD×AW  per-port read address
- rd  out  NRD×XLEN  per-port read data, combinational
- rbusy  out  NRD  busy flag of ra[i], combinational
- iss_valid  in  1  issue strobe: mark iss_rd busy
- iss_rd  in  AW  destination of the issuing instruction
- flush  in  1  clear all busy bits (pipeline squash)
- any_busy  out  1  OR of all busy bits, registered

## Operation
- Reset (reset=0, asynchronous): all registers = 0, all busy bits = 0, any_busy = 0. rd and rbusy follow from the cleared state.
- Write: on a rising edge with we[j]=1 and wa[j]≠0, rf[wa[j]] ← wd[j]. Writes to address 0 are discarded.
- Write conflict (two ports, same address, same cycle): the highest-index port wins. The lower ports' data is dropped, with no error.
- Read: rd[i] = 0 if ra[i]=0, otherwise rf[ra[i]]. Any number of ports may read the same address.
- Scoreboard, per register r≠0, evaluated at each rising edge in priority order:
  - flush=1: busy[r] ← 0 (overrides everything).
  - iss_valid=1 and iss_rd=r: busy[r] ← 1. Issue beats a same-cycle writeback to r, because a newer producer is in flight.
  - any we[j]=1 with wa[j]=r: busy[r] ← 0.
  - Otherwise hold.
- iss_rd=0 is ignored. busy[0] is constant 0.
- rbusy[i] = busy[ra[i]]. See Configuration for same-cycle masking.
- any_busy is registered: 1 on the cycle after any busy bit becomes set, 0 on the cycle after all are clear.
- A writeback to a register that is not busy is legal. Data is written and busy stays 0.

## Timing
- Read latency 0 (combinational from ra and state).
- Write latency 1: the value is visible at rd on the cycle after the write edge, or in the same cycle when bypass is enabled.
- Issue-to-rbusy latency 1 edge. Writeback-to-rbusy-clear latency 1 edge, or 0 with bypass.
- any_busy lags the busy bits by one edge.
- Reset asserted mid-operation: state clears immediately regardless of clk. Writes or issues on the deassertion edge are taken normally.

## Configuration
- REGFILE_MP_BYPASS_EN defined: write-through forwarding.
  - If ra[i]≠0 matches wa[j] with we[j]=1, then rd[i] = wd[j] of the highest such j in the same cycle.
  - rbusy[i] is forced to 0 in that cycle, unless iss_valid=1 and iss_rd=ra[i] in the same cycle.
- REGFILE_MP_BYPASS_EN undefined: no forwarding. rd and rbusy reflect stored state only.
- Every other behaviour is identical in both builds.

## Structure
- Shared package regfile_pkg holds:
  - XLEN_DEFAULT, NREGS_DEFAULT
  - typedef reg_addr_t (logic [AW-1:0] at the defaults)
  - typedef xlen_t
- One natural sub-module: regfile_mp_scoreboard.
  - Contains the busy vector, the set/clear priority logic and the any_busy register.
  - Is instantiated once.
  - The data array and read/bypass muxing stay in the top module.

## Test plan
- Reset, then read all 32 addresses on both ports → rd=0, rbusy=0, any_busy=0. Assert reset mid-run after writes → all reads 0 immediately.
- Write wa[0]=5, wd[0]=0xDEADBEEF; next cycle ra[1]=5 → rd[1]=0xDEADBEEF. Write 0x1234 to address 0 → reads of 0 still return 0.
- Same edge, we=2'b11, wa={7,7}, wd={0xAAAA0000, 0x5555} → rf[7]=0xAAAA0000, port 1 wins.
- Issue iss_rd=3 → rbusy for ra=3 is 1 next cycle and any_busy=1 one cycle later. Writeback we[0] to 3 → rbusy=0 next cycle, any_busy=0 one cycle after that. Issue and writeback to 3 on the same edge → busy stays 1.
- Set busy on 3, 9, 12, then flush=1 with iss_valid=1, iss_rd=4 → all busy 0, including 4.
- With REGFILE_MP_BYPASS_EN: busy 6, then we[1]=1, wa=6, wd=0x42 and ra[0]=6 in the same cycle → rd[0]=0x42, rbusy[0]=0 combinationally. Without the macro → old value and rbusy[0]=1 that cycle.
